digit_board_renderer: RTL
=========================

Name: digit_board_renderer

Overview:
- Pixel-pipeline stage directly upstream of the glyph ROM mux. Holds a COLS x ROWS board of glyph codes and converts VGA counters into a glyph code and glyph row for the mux.
- Reads back the 64-bit glyph row and produces a registered colour pixel, with sync outputs delayed to match.
- Cells are 64x64 px; a blinking inverted cursor highlights one cell.

Parameters:
- X0, 32, board left edge in pixels
- Y0, 16, board top edge in pixels
- COLS, 9, board columns (1..9)
- ROWS, 7, board rows (1..7)
- BLINK_CYCLES, 25000000, clocks per cursor blink half-period
- FG_COLOR, 8'hFF, glyph "on" pixel colour
- BG_COLOR, 8'h00, glyph "off" pixel colour
- GRID_COLOR, 8'h1C, cell border colour
- OUT_COLOR, 8'h00, colour outside the board

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  asynchronous active-low reset
- hCount  in  10  VGA column counter
- vCount  in  10  VGA row counter
- bright  in  1  1 = visible region
- hSync_in  in  1  horizontal sync, aligned with hCount
- vSync_in  in  1  vertical sync, aligned with vCount
- wr_en  in  1  board write strobe
- wr_row  in  3  write cell row
- wr_col  in  4  write cell column
- wr_digit  in  4  glyph code to write (0 = blank, 1..8)
- clear  in  1  synchronous clear of all cells to 0
- cursor_row  in  3  cursor cell row
- cursor_col  in  4  cursor cell column
- digit  out  4  glyph code to the ROM mux
- index_Y  out  6  glyph row to the ROM mux
- spo  in  64  glyph row bitmap returned by the mux (asynchronous)
- rgb  out  8  pixel colour
- hSync_out  out  1  hSync_in delayed 2 clocks
- vSync_out  out  1  vSync_in delayed 2 clocks

Behaviour:
- Reset (Reset_n=0, async):
  - all board cells = 0; pipeline registers cleared
  - rgb = 0, digit = 0, index_Y = 0
  - hSync_out = vSync_out = 1
  - blink counter = 0, blink phase = 0
- Board storage:
  - On a clock edge with clear=1, every cell = 0. clear wins over a simultaneous wr_en.
  - Else if wr_en=1, wr_row<ROWS, wr_col<COLS and wr_digit<=8: cell[wr_row][wr_col] = wr_digit.
  - Otherwise the write is silently ignored.
  - A write is visible to the renderer from the next clock.
- Stage 1 (edge 1), registers:
  - bright, both syncs
  - dx = hCount-X0, dy = vCount-Y0 (10-bit)
  - in_board = (hCount>=X0) & (hCount<X0+64*COLS) & (vCount>=Y0) & (vCount<Y0+64*ROWS)
  - col = dx[9:6], row = dy[8:6], xoff = dx[5:0], yoff = dy[5:0]
  - is_cursor = (row==cursor_row) & (col==cursor_col)
- Between stage 1 and stage 2 (combinational from stage-1 registers):
  - digit = in_board ? cell[row][col] : 0
  - index_Y = yoff
  - The spo bit is sampled the same cycle; the mux is asynchronous.
- Stage 2 (edge 2):
  - pix = spo[63-xoff] (MSB = leftmost pixel)
  - If cursor and blink phase = 1, pix is inverted.
  - rgb priority:
    - !bright → 0
    - !in_board → OUT_COLOR
    - xoff==0 or yoff==0 → GRID_COLOR
    - pix → FG_COLOR
    - else BG_COLOR
  - hSync_out / vSync_out = stage-1 syncs.
- Latency: exactly 2 clocks from hCount/vCount/syncs to rgb/syncs out; counters change every clock with no stalls.
- Blink:
  - Counter runs 0..BLINK_CYCLES-1 and wraps to 0.
  - Phase toggles on the wrap cycle.
  - The cursor is ignored if it lies outside the board.
- Boundaries:
  - Right/bottom board edge exclusive.
  - Stage 2 uses the board contents read in stage 1, so a write mid-frame affects only pixels entering stage 1 after it.
  - Reset asserted mid-line forces outputs to their reset values immediately.

Test Plan:
- Reset: Reset_n=0 for 3 clocks, mid-activity → rgb=0, hSync_out=vSync_out=1, digit=0; after release, all cells read 0.
- Write/render: write cell(0,0)=3; drive hCount=X0+10, vCount=Y0+5, bright=1 →
  - one clock later digit=3, index_Y=5
  - bench spo with bit 53 set → rgb=FG_COLOR 2 clocks after input
  - bit 53 clear → BG_COLOR
- Grid/outside:
  - hCount=X0, vCount=Y0+20 → GRID_COLOR
  - hCount=X0+64*COLS → OUT_COLOR, digit=0
  - bright=0 → rgb=0
- Write rules:
  - wr_digit=9, or wr_col=COLS → cell unchanged
  - clear and wr_en in the same cycle → cell = 0
- Cursor blink: BLINK_CYCLES=4, cursor=(1,2), pixel inside that cell with spo bit=1 → rgb FG for 4 clocks, BG for next 4, repeating.
- Sync alignment: toggle hSync_in at cycle t → hSync_out toggles at t+2, in step with the corresponding rgb pixel.

Source files
------------

// File: rtl/digit_board_renderer.sv
// Glyph board renderer: keeps a COLS x ROWS board of glyph codes, turns VGA
// counters into a glyph code / glyph row for the ROM mux, and returns a
// registered colour pixel two clocks after the counters, syncs delayed to match.
module digit_board_renderer #(
  parameter int          X0           = 32,
  parameter int          Y0           = 16,
  parameter int          COLS         = 9,
  parameter int          ROWS         = 7,
  parameter int          BLINK_CYCLES = 25000000,
  parameter logic [7:0]  FG_COLOR     = 8'hFF,
  parameter logic [7:0]  BG_COLOR     = 8'h00,
  parameter logic [7:0]  GRID_COLOR   = 8'h1C,
  parameter logic [7:0]  OUT_COLOR    = 8'h00
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  input  logic        bright,
  input  logic        hSync_in,
  input  logic        vSync_in,
  input  logic        wr_en,
  input  logic [2:0]  wr_row,
  input  logic [3:0]  wr_col,
  input  logic [3:0]  wr_digit,
  input  logic        clear,
  input  logic [2:0]  cursor_row,
  input  logic [3:0]  cursor_col,
  output logic [3:0]  digit,
  output logic [5:0]  index_Y,
  input  logic [63:0] spo,
  output logic [7:0]  rgb,
  output logic        hSync_out,
  output logic        vSync_out
);

  localparam int              CW      = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(BLINK_CYCLES - 1);
  localparam logic [10:0]     X_LO    = 11'(X0);
  localparam logic [10:0]     X_HI    = 11'(X0 + 64 * COLS);
  localparam logic [10:0]     Y_LO    = 11'(Y0);
  localparam logic [10:0]     Y_HI    = 11'(Y0 + 64 * ROWS);
  localparam logic [9:0]      X0_V    = 10'(X0);
  localparam logic [9:0]      Y0_V    = 10'(Y0);
  localparam logic [3:0]      ROWS_L  = 4'(ROWS);
  localparam logic [4:0]      COLS_L  = 5'(COLS);

  typedef struct packed {
    logic       bright;
    logic       hs;
    logic       vs;
    logic       in_board;
    logic       is_cur;
    logic [3:0] col;
    logic [2:0] row;
    logic [5:0] xoff;
    logic [5:0] yoff;
  } s1_t;

  logic [ROWS-1:0][COLS-1:0][3:0] board;
  s1_t                            s1;
  logic [CW-1:0]                  blink_cnt;
  logic                           blink_ph;

  logic [9:0] dx;
  logic [8:0] dy;
  logic       in_board_c;
  logic       cur_ok;
  logic       pix;

  // Board storage: clear beats write; out-of-range or bad glyph writes are dropped
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      board <= '0;
    end else if (clear) begin
      board <= '0;
    end else if (wr_en && ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L) &&
                 (wr_digit <= 4'd8)) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (wr_row == 3'(r) && wr_col == 4'(c)) board[r][c] <= wr_digit;
    end
  end

  assign dx         = hCount - X0_V;
  assign dy         = 9'(vCount - Y0_V);
  assign in_board_c = ({1'b0, hCount} >= X_LO) && ({1'b0, hCount} < X_HI) &&
                      ({1'b0, vCount} >= Y_LO) && ({1'b0, vCount} < Y_HI);
  // A cursor parked outside the board never matches a cell
  assign cur_ok     = ({1'b0, cursor_row} < ROWS_L) && ({1'b0, cursor_col} < COLS_L);

  // Stage 1: register pixel position, cell coordinates and cursor hit
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1    <= '0;
      s1.hs <= 1'b1;
      s1.vs <= 1'b1;
    end else begin
      s1.bright   <= bright;
      s1.hs       <= hSync_in;
      s1.vs       <= vSync_in;
      s1.in_board <= in_board_c;
      s1.col      <= dx[9:6];
      s1.row      <= dy[8:6];
      s1.xoff     <= dx[5:0];
      s1.yoff     <= dy[5:0];
      s1.is_cur   <= cur_ok && (dy[8:6] == cursor_row) && (dx[9:6] == cursor_col);
    end
  end

  // Cell lookup for the ROM mux; only addresses real cells
  always_comb begin
    digit = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (s1.in_board && s1.row == 3'(r) && s1.col == 4'(c)) digit = board[r][c];
  end

  assign index_Y = s1.yoff;
  // MSB of the glyph row is the leftmost pixel: 63 - xoff == ~xoff
  assign pix     = spo[~s1.xoff] ^ (s1.is_cur & blink_ph);

  // Stage 2: colour priority and delayed syncs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rgb       <= '0;
      hSync_out <= 1'b1;
      vSync_out <= 1'b1;
    end else begin
      hSync_out <= s1.hs;
      vSync_out <= s1.vs;
      if (!s1.bright)                           rgb <= '0;
      else if (!s1.in_board)                    rgb <= OUT_COLOR;
      else if (s1.xoff == '0 || s1.yoff == '0)  rgb <= GRID_COLOR;
      else if (pix)                             rgb <= FG_COLOR;
      else                                      rgb <= BG_COLOR;
    end
  end

  // Cursor blink: free-running counter, phase flips on each wrap
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == CNT_MAX) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule
